sad_tree_ctrl: RTL and testbench
================================

SAD_TREE_CTRL -- requirements
Module: sad_tree_ctrl

Interface
REQ-001 Parameter ROWS, default 8: accumulation beats per candidate block (one original column per beat); ROWS >= 2.
REQ-002 Parameter NUM_ITER, default 4: candidate iterations per search; NUM_ITER >= 1.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  search request pulse; honoured only in IDLE.
REQ-006 pvso_mode  input  1  1 = right-side (PVSO 2D) SADs are also sequenced; sampled when start is accepted.
REQ-007 data_valid  input  1  original and candidate pixels valid this cycle.
REQ-008 abort  input  1  synchronous search cancel.
REQ-009 sad_clear  output  1  zeroes the left-side SAD accumulators.
REQ-010 reset_right_sads  output  1  zeroes the right-side SAD accumulators.
REQ-011 enable_left_side  output  1  left-side accumulate enable.
REQ-012 enable_right_side  output  1  right-side accumulate enable.
REQ-013 sel  output  1  first-beat marker; the SAD loads the lambda seed instead of accumulating.
REQ-014 enable_out  output  1  last-beat marker; the SAD output register captures.
REQ-015 sad_valid_left  output  1  left SADs (sad_0..5) hold a final result.
REQ-016 sad_valid_right  output  1  right SADs (sad_6..11) hold a final result.
REQ-017 iter_count  output  clog2(NUM_ITER) (minimum 1)  current iteration index.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle search-complete pulse.

Function
REQ-020 The FSM SHALL have exactly five states, IDLE, CLEAR, ACCUM, DRAIN and FINISH, held in a state register.
REQ-021 IDLE->CLEAR when start=1; iter_count:=0; pvso_mode is latched into pvso_q.
REQ-022 CLEAR lasts 1 cycle and drives sad_clear=1, plus reset_right_sads=pvso_q; row_count:=0; CLEAR->ACCUM.
REQ-023 ACCUM: enable_left_side = data_valid.
REQ-024 ACCUM: row_count increments only on cycles where data_valid=1.
REQ-025 data_valid=0 in ACCUM freezes row_count, state and iter_count; no enable is asserted for that beat.
REQ-026 sel = ACCUM & data_valid & (row_count==0).
REQ-027 enable_out = ACCUM & data_valid & (row_count==ROWS-1).
REQ-028 The beat with row_count==ROWS-1 and data_valid=1 SHALL move ACCUM->DRAIN.
REQ-029 enable_right_side = pvso_q & left_en_q, where left_en_q is enable_left_side registered one cycle; the right side therefore trails the left by exactly one cycle, including across stalls.
REQ-030 DRAIN lasts 1 cycle and asserts sad_valid_left=1.
REQ-031 DRAIN->CLEAR with iter_count+1 when iter_count<NUM_ITER-1; otherwise DRAIN->FINISH.
REQ-032 sad_valid_right is a registered copy of (DRAIN & pvso_q); it is high in the cycle after DRAIN.
REQ-033 FINISH lasts 1 cycle, asserts done=1, then goes FINISH->IDLE.
REQ-034 start while busy SHALL be ignored, with no queuing.
REQ-035 abort=1 in any non-IDLE state forces IDLE on the next edge and clears left_en_q; done, sad_valid_left and sad_valid_right are not asserted.
REQ-036 abort=1 together with start=1 in IDLE SHALL keep the block in IDLE.
REQ-037 Outputs other than enable_left_side, sel and enable_out SHALL depend only on registers.
REQ-038 row_count SHALL never exceed ROWS-1.
REQ-039 iter_count SHALL never exceed NUM_ITER-1.

Reset
REQ-040 reset=1 SHALL asynchronously force IDLE.
REQ-041 reset=1 SHALL clear row_count, iter_count, pvso_q and left_en_q to 0.
REQ-042 While reset=1, every output SHALL be 0.
REQ-043 Reset asserted mid-search SHALL abandon the search; after release the block waits in IDLE for a new start.

Verification (ROWS=8, NUM_ITER=2, start pulsed in cycle 0)
REQ-044 pvso_mode=1, data_valid held 1 -> CLEAR in cycles 1 and 11; sel in cycles 2 and 12; enable_out in cycles 9 and 19; sad_valid_left in cycles 10 and 20; sad_valid_right and enable_right_side timing per REQ-029/REQ-032; done in cycle 21; busy=0 from cycle 22.
REQ-045 pvso_mode=0, same stimulus -> enable_right_side, reset_right_sads and sad_valid_right never assert; all other timing matches REQ-044.
REQ-046 data_valid=0 in cycles 4-5 of the first iteration -> enable_out moves to cycle 11; enable_right_side is also low in cycles 5-6; done moves to cycle 23.
REQ-047 abort in cycle 6 -> IDLE in cycle 7; no done or sad_valid_* pulse occurs; a start in cycle 8 produces sad_clear in cycle 9.
REQ-048 reset asserted in cycle 14 -> all outputs 0 immediately; start pulses while busy (for example cycle 5) have no effect on timing.

Source files
------------

// File: rtl/sad_tree_ctrl.sv
// Sequencer for the SAD adder tree: clears, accumulates ROWS beats per candidate,
// drains results and repeats for NUM_ITER candidates, optionally driving the PVSO right side.
module sad_tree_ctrl #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned NUM_ITER = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic pvso_mode,
    input  logic data_valid,
    input  logic abort,
    output logic sad_clear,
    output logic reset_right_sads,
    output logic enable_left_side,
    output logic enable_right_side,
    output logic sel,
    output logic enable_out,
    output logic sad_valid_left,
    output logic sad_valid_right,
    output logic [((NUM_ITER > 1) ? $clog2(NUM_ITER) : 1)-1:0] iter_count,
    output logic busy,
    output logic done
);

    localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IterW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [RowW-1:0]  RowLast  = RowW'(ROWS - 1);
    localparam logic [IterW-1:0] IterLast = IterW'(NUM_ITER - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StDrain,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [IterW-1:0] iter_q, iter_d;
    logic             pvso_q, pvso_d;
    logic             left_en_q, left_en_d;
    logic             svr_q, svr_d;

    logic in_accum;
    logic last_row;

    assign in_accum = (state_q == StAccum);
    assign last_row = (row_q == RowLast);

    // Beat-qualified strobes are the only outputs allowed to see data_valid directly.
    assign enable_left_side  = in_accum & data_valid;
    assign sel               = in_accum & data_valid & (row_q == '0);
    assign enable_out        = in_accum & data_valid & last_row;

    assign sad_clear         = (state_q == StClear);
    assign reset_right_sads  = (state_q == StClear) & pvso_q;
    assign enable_right_side = pvso_q & left_en_q;
    assign sad_valid_left    = (state_q == StDrain);
    assign sad_valid_right   = svr_q;
    assign iter_count        = iter_q;
    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StFinish);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        iter_d    = iter_q;
        pvso_d    = pvso_q;
        left_en_d = enable_left_side;
        svr_d     = (state_q == StDrain) & pvso_q & ~abort;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StClear;
                    iter_d  = '0;
                    pvso_d  = pvso_mode;
                end
            end
            StClear: begin
                row_d   = '0;
                state_d = StAccum;
            end
            StAccum: begin
                if (data_valid) begin
                    if (last_row) begin
                        row_d   = '0;
                        state_d = StDrain;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (iter_q < IterLast) begin
                    iter_d  = iter_q + 1'b1;
                    state_d = StClear;
                end else begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort drops the search outright; the right side must not trail into IDLE.
        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            left_en_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            row_q     <= '0;
            iter_q    <= '0;
            pvso_q    <= 1'b0;
            left_en_q <= 1'b0;
            svr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            iter_q    <= iter_d;
            pvso_q    <= pvso_d;
            left_en_q <= left_en_d;
            svr_q     <= svr_d;
        end
    end

`ifndef SYNTHESIS
    a_row_bound : assert property (@(posedge clock) disable iff (reset) row_q <= RowLast);
    a_iter_bound : assert property (@(posedge clock) disable iff (reset) iter_q <= IterLast);
`endif

endmodule

// File: tb/tb_sad_tree_ctrl.sv
// Directed bench: each scenario records 32 cycles of every output as a bit trace
// and compares it against hand-derived masks for ROWS=8, NUM_ITER=2.
module tb_sad_tree_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic start, pvso_mode, data_valid, abort;
    logic sad_clear, reset_right_sads, enable_left_side, enable_right_side;
    logic sel, enable_out, sad_valid_left, sad_valid_right, busy, done;
    logic [0:0] iter_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] t_clr, t_rrs, t_ele, t_ers, t_sel, t_eout, t_svl, t_svr, t_busy, t_done, t_iter;

    sad_tree_ctrl #(.ROWS(8), .NUM_ITER(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .pvso_mode        (pvso_mode),
        .data_valid       (data_valid),
        .abort            (abort),
        .sad_clear        (sad_clear),
        .reset_right_sads (reset_right_sads),
        .enable_left_side (enable_left_side),
        .enable_right_side(enable_right_side),
        .sel              (sel),
        .enable_out       (enable_out),
        .sad_valid_left   (sad_valid_left),
        .sad_valid_right  (sad_valid_right),
        .iter_count       (iter_count),
        .busy             (busy),
        .done             (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] bt(input int n);
        return rng(n, n);
    endfunction

    // Cycle k starts at rising edge k; inputs change 1 time unit after it, outputs sampled at negedge.
    task automatic run_vec(input logic pvso, input logic [31:0] start_m, input logic [31:0] dvlow_m,
                           input logic [31:0] abort_m, input logic [31:0] rst_m);
        reset = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b1; pvso_mode = pvso;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clock);
            #1;
            start      = start_m[i];
            data_valid = ~dvlow_m[i];
            abort      = abort_m[i];
            reset      = rst_m[i];
            @(negedge clock);
            t_clr[i]  = sad_clear;        t_rrs[i]  = reset_right_sads;
            t_ele[i]  = enable_left_side; t_ers[i]  = enable_right_side;
            t_sel[i]  = sel;              t_eout[i] = enable_out;
            t_svl[i]  = sad_valid_left;   t_svr[i]  = sad_valid_right;
            t_busy[i] = busy;             t_done[i] = done;
            t_iter[i] = iter_count[0];
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
    endtask

    task automatic check_all(input string n, input logic [31:0] clr, input logic [31:0] rrs,
                             input logic [31:0] ele, input logic [31:0] ers, input logic [31:0] sl,
                             input logic [31:0] eo, input logic [31:0] svl, input logic [31:0] svr,
                             input logic [31:0] bsy, input logic [31:0] dn, input logic [31:0] it);
        check_eq({n, ".sad_clear"}, t_clr, clr);
        check_eq({n, ".reset_right_sads"}, t_rrs, rrs);
        check_eq({n, ".enable_left_side"}, t_ele, ele);
        check_eq({n, ".enable_right_side"}, t_ers, ers);
        check_eq({n, ".sel"}, t_sel, sl);
        check_eq({n, ".enable_out"}, t_eout, eo);
        check_eq({n, ".sad_valid_left"}, t_svl, svl);
        check_eq({n, ".sad_valid_right"}, t_svr, svr);
        check_eq({n, ".busy"}, t_busy, bsy);
        check_eq({n, ".done"}, t_done, dn);
        check_eq({n, ".iter_count"}, t_iter, it);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b0; data_valid = 1'b1; pvso_mode = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("reset.outputs",
                 {21'd0, sad_clear, reset_right_sads, enable_left_side, enable_right_side, sel,
                  enable_out, sad_valid_left, sad_valid_right, busy, done, iter_count},
                 32'd0);

        // Full PVSO search, data_valid always high.
        run_vec(1'b1, bt(0), 32'd0, 32'd0, 32'd0);
        check_all("pvso", bt(1) | bt(11), bt(1) | bt(11), rng(2, 9) | rng(12, 19),
                  rng(3, 10) | rng(13, 20), bt(2) | bt(12), bt(9) | bt(19), bt(10) | bt(20),
                  bt(11) | bt(21), rng(1, 21), bt(21), rng(11, 31));

        // Left side only.
        run_vec(1'b0, bt(0), 32'd0, 32'd0, 32'd0);
        check_all("left", bt(1) | bt(11), 32'd0, rng(2, 9) | rng(12, 19), 32'd0,
                  bt(2) | bt(12), bt(9) | bt(19), bt(10) | bt(20), 32'd0, rng(1, 21), bt(21),
                  rng(11, 31));

        // Two-cycle stall in the first iteration.
        run_vec(1'b1, bt(0), rng(4, 5), 32'd0, 32'd0);
        check_all("stall", bt(1) | bt(13), bt(1) | bt(13), rng(2, 3) | rng(6, 11) | rng(14, 21),
                  rng(3, 4) | rng(7, 12) | rng(15, 22), bt(2) | bt(14), bt(11) | bt(21),
                  bt(12) | bt(22), bt(13) | bt(23), rng(1, 23), bt(23), rng(13, 31));

        // Abort mid-accumulate, then a fresh search.
        run_vec(1'b1, bt(0) | bt(8), 32'd0, bt(6), 32'd0);
        check_all("abort", bt(1) | bt(9) | bt(19), bt(1) | bt(9) | bt(19),
                  rng(2, 6) | rng(10, 17) | rng(20, 27), rng(3, 6) | rng(11, 18) | rng(21, 28),
                  bt(2) | bt(10) | bt(20), bt(17) | bt(27), bt(18) | bt(28), bt(19) | bt(29),
                  rng(1, 6) | rng(9, 29), bt(29), rng(19, 31));

        // Ignored start while busy, reset mid-search, then start+abort together in IDLE.
        run_vec(1'b1, bt(0) | bt(5) | bt(20), 32'd0, bt(20), bt(14));
        check_all("reset", bt(1) | bt(11), bt(1) | bt(11), rng(2, 9) | rng(12, 13),
                  rng(3, 10) | bt(13), bt(2) | bt(12), bt(9), bt(10), bt(11), rng(1, 13), 32'd0,
                  rng(11, 13));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
